// File: rtl/quadtree_local_ni_pkg.sv
// rtl/quadtree_local_ni_pkg.sv - shared constants for the quadtree LOCAL-port network interface
package quadtree_local_ni_pkg;

    localparam int ROUTER_WIDTH = 32;
    localparam int DIR_LOCAL    = 0;

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// rtl/ni_sync_fifo.sv - synchronous FIFO with combinational head output
module ni_sync_fifo
    import quadtree_local_ni_pkg::*;
#(
    parameter int WIDTH = ROUTER_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = ptr_bits(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/quadtree_local_ni.sv
// rtl/quadtree_local_ni.sv - PE <-> router LOCAL port interface with credit flow control
module quadtree_local_ni
    import quadtree_local_ni_pkg::*;
#(
    parameter int FLIT_W      = ROUTER_WIDTH,
    parameter int INJ_DEPTH   = 4,
    parameter int EJ_DEPTH    = 4,
    parameter int CREDIT_INIT = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pe_tx_valid,
    input  logic [FLIT_W-1:0]                pe_tx_data,
    output logic                             pe_tx_ready,
    output logic                             noc_tx_valid,
    output logic [FLIT_W-1:0]                noc_tx_data,
    input  logic                             noc_tx_credit,
    input  logic                             noc_rx_valid,
    input  logic [FLIT_W-1:0]                noc_rx_data,
    output logic                             noc_rx_credit,
    output logic                             pe_rx_valid,
    output logic [FLIT_W-1:0]                pe_rx_data,
    input  logic                             pe_rx_ready,
    output logic [$clog2(CREDIT_INIT+1)-1:0] inj_credit,
    output logic                             err_sticky
);
    localparam int            CW       = $clog2(CREDIT_INIT + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDIT_INIT);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);

    logic              w_inj_full, w_inj_empty, w_inj_push, w_send;
    logic [FLIT_W-1:0] w_inj_head;
    logic              w_ej_full, w_ej_empty, w_ej_push, w_ej_pop;
    logic              w_ej_overflow, w_credit_overflow;

    logic [CW-1:0]     r_credit;
    logic              r_tx_valid;
    logic [FLIT_W-1:0] r_tx_data;
    logic              r_rx_credit;
    logic              r_err;

    assign pe_tx_ready = !w_inj_full;
    assign w_inj_push  = pe_tx_valid && !w_inj_full;
    assign w_send      = !w_inj_empty && (r_credit != '0);

    ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_inj_push),
        .pop   (w_send),
        .din   (pe_tx_data),
        .dout  (w_inj_head),
        .full  (w_inj_full),
        .empty (w_inj_empty)
    );

    // A write into a full ejection FIFO is still taken if the PE frees a slot this cycle.
    assign w_ej_pop      = !w_ej_empty && pe_rx_ready;
    assign w_ej_push     = noc_rx_valid && (!w_ej_full || w_ej_pop);
    assign w_ej_overflow = noc_rx_valid && w_ej_full && !w_ej_pop;

    ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_ej_push),
        .pop   (w_ej_pop),
        .din   (noc_rx_data),
        .dout  (pe_rx_data),
        .full  (w_ej_full),
        .empty (w_ej_empty)
    );

    assign pe_rx_valid       = !w_ej_empty;
    assign w_credit_overflow = noc_tx_credit && !w_send && (r_credit == CRED_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit    <= CRED_MAX;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_rx_credit <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (noc_tx_credit && !w_send && (r_credit != CRED_MAX))
                r_credit <= r_credit + CRED_ONE;
            else if (w_send && !noc_tx_credit)
                r_credit <= r_credit - CRED_ONE;
            r_tx_valid  <= w_send;
            if (w_send) r_tx_data <= w_inj_head;
            r_rx_credit <= w_ej_pop;
            if (w_credit_overflow || w_ej_overflow) r_err <= 1'b1;
        end
    end

    assign noc_tx_valid  = r_tx_valid;
    assign noc_tx_data   = r_tx_data;
    assign noc_rx_credit = r_rx_credit;
    assign inj_credit    = r_credit;
    assign err_sticky    = r_err;

endmodule

// File: tb/tb_quadtree_local_ni.sv
// tb/tb_quadtree_local_ni.sv - self-checking bench for quadtree_local_ni
module tb_quadtree_local_ni;
    localparam int W   = 32;
    localparam int INJ = 4;
    localparam int EJ  = 4;
    localparam int CI  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pe_tx_valid = 1'b0;
    logic [W-1:0] pe_tx_data = '0;
    logic         pe_tx_ready;
    logic         noc_tx_valid;
    logic [W-1:0] noc_tx_data;
    logic         noc_tx_credit = 1'b0;
    logic         noc_rx_valid = 1'b0;
    logic [W-1:0] noc_rx_data = '0;
    logic         noc_rx_credit;
    logic         pe_rx_valid;
    logic [W-1:0] pe_rx_data;
    logic         pe_rx_ready = 1'b0;
    logic [2:0]   inj_credit;
    logic         err_sticky;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_inj[$];
    logic [W-1:0] m_ej[$];
    int           m_cred;
    bit           m_txv;
    logic [W-1:0] m_txd;
    bit           m_rxc;
    bit           m_err;

    quadtree_local_ni #(.FLIT_W(W), .INJ_DEPTH(INJ), .EJ_DEPTH(EJ), .CREDIT_INIT(CI)) dut (
        .clk(clk), .rst(rst),
        .pe_tx_valid(pe_tx_valid), .pe_tx_data(pe_tx_data), .pe_tx_ready(pe_tx_ready),
        .noc_tx_valid(noc_tx_valid), .noc_tx_data(noc_tx_data), .noc_tx_credit(noc_tx_credit),
        .noc_rx_valid(noc_rx_valid), .noc_rx_data(noc_rx_data), .noc_rx_credit(noc_rx_credit),
        .pe_rx_valid(pe_rx_valid), .pe_rx_data(pe_rx_data), .pe_rx_ready(pe_rx_ready),
        .inj_credit(inj_credit), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_inj.delete();
        m_ej.delete();
        m_cred = CI;
        m_txv  = 0;
        m_txd  = '0;
        m_rxc  = 0;
        m_err  = 0;
    endtask

    // Drives one clock cycle and advances the reference model; returns at posedge+1.
    task automatic cycle(input bit tv, input logic [W-1:0] td, input bit tcr,
                         input bit rv, input logic [W-1:0] rd, input bit rr);
        int  inj_n, ej_n;
        bit  acc, snd, pop;
        pe_tx_valid   = tv;
        pe_tx_data    = td;
        noc_tx_credit = tcr;
        noc_rx_valid  = rv;
        noc_rx_data   = rd;
        pe_rx_ready   = rr;
        inj_n = m_inj.size();
        ej_n  = m_ej.size();
        acc = tv && (inj_n < INJ);
        snd = (inj_n > 0) && (m_cred != 0);
        pop = (ej_n > 0) && rr;
        if (snd) m_txd = m_inj.pop_front();
        m_txv = snd;
        if (acc) m_inj.push_back(td);
        if (tcr && !snd && m_cred == CI) m_err = 1;
        else m_cred = m_cred - int'(snd) + int'(tcr);
        if (pop) void'(m_ej.pop_front());
        if (rv) begin
            if (ej_n < EJ || pop) m_ej.push_back(rd);
            else m_err = 1;
        end
        m_rxc = pop;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pe_tx_valid = 0; noc_tx_credit = 0; noc_rx_valid = 0; pe_rx_ready = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (pe_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_pe_tx_ready got %b exp 1", pe_tx_ready); end
        if (pe_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_pe_rx_valid got %b exp 0", pe_rx_valid); end
        if (noc_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_noc_tx_valid got %b exp 0", noc_tx_valid); end
        if (noc_tx_data !== '0) begin errors++; $display("FAIL reset_noc_tx_data got %h exp 0", noc_tx_data); end
        if (noc_rx_credit !== 1'b0) begin errors++; $display("FAIL reset_noc_rx_credit got %b exp 0", noc_rx_credit); end
        if (inj_credit !== 3'd4) begin errors++; $display("FAIL reset_inj_credit got %0d exp 4", inj_credit); end
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_sticky); end
    endtask

    task automatic test_inject_stall();
        logic [W-1:0] got[$];
        int           not_ready;
        do_reset();
        not_ready = 0;
        for (int i = 0; i < 6; i++) begin
            if (pe_tx_ready !== 1'b1) not_ready++;
            cycle(1, W'(32'hA0 + i), 0, 0, '0, 0);
            if (noc_tx_valid === 1'b1) got.push_back(noc_tx_data);
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            if (noc_tx_valid === 1'b1) got.push_back(noc_tx_data);
        end
        checks++;
        if (not_ready != 0) begin errors++; $display("FAIL stall_accept_all got %0d refusals exp 0", not_ready); end
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL stall_pulse_count got %0d exp 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== W'(32'hA0 + i)) begin errors++; $display("FAIL stall_data%0d got %h exp %h", i, got[i], 32'hA0 + i); end
        end
        checks++;
        if (inj_credit !== 3'd0) begin errors++; $display("FAIL stall_credit got %0d exp 0", inj_credit); end
        cycle(1, 32'hA6, 0, 0, '0, 0);
        cycle(1, 32'hA7, 0, 0, '0, 0);
        checks++;
        if (pe_tx_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b exp 0", pe_tx_ready); end
        cycle(1, 32'hA8, 0, 0, '0, 0);
    endtask

    task automatic test_credit_return();
        cycle(0, '0, 1, 0, '0, 0);
        checks += 2;
        if (noc_tx_valid !== 1'b0) begin errors++; $display("FAIL cred_early_valid got %b exp 0", noc_tx_valid); end
        if (inj_credit !== 3'd1) begin errors++; $display("FAIL cred_after_pulse got %0d exp 1", inj_credit); end
        idle();
        checks += 3;
        if (noc_tx_valid !== 1'b1) begin errors++; $display("FAIL cred_a4_valid got %b exp 1", noc_tx_valid); end
        if (noc_tx_data !== 32'hA4) begin errors++; $display("FAIL cred_a4_data got %h exp a4", noc_tx_data); end
        if (inj_credit !== 3'd0) begin errors++; $display("FAIL cred_a4_count got %0d exp 0", inj_credit); end
        cycle(0, '0, 1, 0, '0, 0);
        cycle(0, '0, 1, 0, '0, 0);
        checks += 2;
        if (noc_tx_data !== 32'hA5 || noc_tx_valid !== 1'b1) begin errors++; $display("FAIL cred_a5 got %b/%h exp 1/a5", noc_tx_valid, noc_tx_data); end
        if (inj_credit !== 3'd1) begin errors++; $display("FAIL cred_simultaneous got %0d exp 1", inj_credit); end
        idle();
        checks++;
        if (noc_tx_data !== 32'hA6 || inj_credit !== 3'd0) begin errors++; $display("FAIL cred_a6 got %h/%0d exp a6/0", noc_tx_data, inj_credit); end
        cycle(0, '0, 1, 0, '0, 0);
        idle();
        checks++;
        if (noc_tx_data !== 32'hA7 || noc_tx_valid !== 1'b1) begin errors++; $display("FAIL cred_a7 got %b/%h exp 1/a7", noc_tx_valid, noc_tx_data); end
        cycle(0, '0, 1, 0, '0, 0);
        idle();
        checks += 2;
        if (noc_tx_valid !== 1'b0) begin errors++; $display("FAIL cred_no_a8 got %b/%h exp 0", noc_tx_valid, noc_tx_data); end
        if (inj_credit !== 3'd1) begin errors++; $display("FAIL cred_idle_count got %0d exp 1", inj_credit); end
    endtask

    task automatic test_ejection();
        logic [W-1:0] exp_d[3] = '{32'h11, 32'h22, 32'h33};
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 1, exp_d[i], 0);
        idle();
        checks += 2;
        if (pe_rx_valid !== 1'b1 || pe_rx_data !== 32'h11) begin errors++; $display("FAIL ej_head got %b/%h exp 1/11", pe_rx_valid, pe_rx_data); end
        if (noc_rx_credit !== 1'b0) begin errors++; $display("FAIL ej_no_credit got %b exp 0", noc_rx_credit); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (pe_rx_data !== exp_d[i]) begin errors++; $display("FAIL ej_order%0d got %h exp %h", i, pe_rx_data, exp_d[i]); end
            cycle(0, '0, 0, 0, '0, 1);
            if (noc_rx_credit !== 1'b1) begin errors++; $display("FAIL ej_credit%0d got %b exp 1", i, noc_rx_credit); end
        end
        idle();
        checks += 2;
        if (noc_rx_credit !== 1'b0) begin errors++; $display("FAIL ej_credit_end got %b exp 0", noc_rx_credit); end
        if (pe_rx_valid !== 1'b0) begin errors++; $display("FAIL ej_empty got %b exp 0", pe_rx_valid); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] v[5];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v[i] = $urandom;
            cycle(0, '0, 0, 1, v[i], 0);
            if (i == 3) begin
                checks++;
                if (err_sticky !== 1'b0) begin errors++; $display("FAIL ovf_err_early got %b exp 0", err_sticky); end
            end
        end
        checks++;
        if (err_sticky !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err_sticky); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pe_rx_valid !== 1'b1 || pe_rx_data !== v[i]) begin errors++; $display("FAIL ovf_data%0d got %b/%h exp 1/%h", i, pe_rx_valid, pe_rx_data, v[i]); end
            cycle(0, '0, 0, 0, '0, 1);
        end
        checks++;
        if (pe_rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got %b/%h exp 0", pe_rx_valid, pe_rx_data); end
    endtask

    task automatic test_extra_credit();
        do_reset();
        cycle(0, '0, 1, 0, '0, 0);
        checks += 2;
        if (inj_credit !== 3'd4) begin errors++; $display("FAIL xcred_count got %0d exp 4", inj_credit); end
        if (err_sticky !== 1'b1) begin errors++; $display("FAIL xcred_err got %b exp 1", err_sticky); end
        idle();
        checks++;
        if (err_sticky !== 1'b1) begin errors++; $display("FAIL xcred_sticky got %b exp 1", err_sticky); end
    endtask

    task automatic test_async_reset();
        int bad;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, W'(32'hC0 + i), 0, (i < 2), W'(32'h50 + i), 0);
        #2;
        rst = 1'b0;
        #1;
        checks += 6;
        if (pe_rx_valid !== 1'b0) begin errors++; $display("FAIL arst_pe_rx_valid got %b exp 0", pe_rx_valid); end
        if (pe_tx_ready !== 1'b1) begin errors++; $display("FAIL arst_pe_tx_ready got %b exp 1", pe_tx_ready); end
        if (noc_tx_valid !== 1'b0) begin errors++; $display("FAIL arst_noc_tx_valid got %b exp 0", noc_tx_valid); end
        if (noc_tx_data !== '0) begin errors++; $display("FAIL arst_noc_tx_data got %h exp 0", noc_tx_data); end
        if (inj_credit !== 3'd4) begin errors++; $display("FAIL arst_credit got %0d exp 4", inj_credit); end
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", err_sticky); end
        pe_tx_valid = 0; noc_rx_valid = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, '0, 0, 0, '0, 1);
            if (noc_tx_valid !== 1'b0 || noc_rx_credit !== 1'b0 || inj_credit !== 3'd4) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL arst_spurious got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_random();
        bit tv, tcr, rv, rr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tv  = ($urandom % 3) != 0;
            tcr = (($urandom % 2) != 0) && (m_cred < CI);
            rv  = ($urandom % 2) != 0;
            rr  = ($urandom % 3) == 0;
            cycle(tv, $urandom, tcr, rv, $urandom, rr);
            checks += 8;
            if (noc_tx_valid !== m_txv) begin errors++; $display("FAIL rnd_tx_valid@%0d got %b exp %b", n, noc_tx_valid, m_txv); end
            if (noc_tx_data !== m_txd) begin errors++; $display("FAIL rnd_tx_data@%0d got %h exp %h", n, noc_tx_data, m_txd); end
            if (pe_tx_ready !== (m_inj.size() < INJ)) begin errors++; $display("FAIL rnd_tx_ready@%0d got %b exp %b", n, pe_tx_ready, m_inj.size() < INJ); end
            if (pe_rx_valid !== (m_ej.size() != 0)) begin errors++; $display("FAIL rnd_rx_valid@%0d got %b exp %b", n, pe_rx_valid, m_ej.size() != 0); end
            if (m_ej.size() != 0 && pe_rx_data !== m_ej[0]) begin errors++; $display("FAIL rnd_rx_data@%0d got %h exp %h", n, pe_rx_data, m_ej[0]); end
            if (noc_rx_credit !== m_rxc) begin errors++; $display("FAIL rnd_rx_credit@%0d got %b exp %b", n, noc_rx_credit, m_rxc); end
            if (inj_credit !== 3'(m_cred)) begin errors++; $display("FAIL rnd_credit@%0d got %0d exp %0d", n, inj_credit, m_cred); end
            if (err_sticky !== m_err) begin errors++; $display("FAIL rnd_err@%0d got %b exp %b", n, err_sticky, m_err); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_inject_stall();
        test_credit_return();
        test_ejection();
        test_overflow();
        test_extra_credit();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
